// File: rtl/mc_phase_seq.sv
// mc_phase_seq: one-hot phase sequencer for the multi-cycle MIPS core with
// per-class lengths, memory wait timeout, exception abort, stall and retire count.
module mc_phase_seq #(
  parameter int WAIT_W     = 4,
  parameter int WAIT_LIMIT = 15,
  parameter int RET_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       irfunc,
  input  logic [4:0]       regimm,
  input  logic             error,
  input  logic             mem_ready,
  input  logic             stall,
  output logic [4:0]       p,
  output logic             instr_done,
  output logic             exc_abort,
  output logic             bus_err,
  output logic [RET_W-1:0] retired
);
  localparam logic [4:0] S_F = 5'b00001;
  localparam logic [4:0] S_D = 5'b00010;
  localparam logic [4:0] S_E = 5'b00100;
  localparam logic [4:0] S_M = 5'b01000;
  localparam logic [4:0] S_W = 5'b10000;
  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_ALU   = 3'd1;
  localparam logic [2:0] C_LOAD  = 3'd2;
  localparam logic [2:0] C_STORE = 3'd3;
  localparam logic [2:0] C_BR    = 3'd4;
  localparam logic [2:0] C_JMP   = 3'd5;
  localparam logic [2:0] C_ILL   = 3'd6;

  logic [4:0]        r_p, w_p_nxt;
  logic [2:0]        r_cls, w_cls_nxt, w_cls;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              r_done, w_done_nxt;
  logic              r_abort, w_abort_nxt;
  logic              r_bus_err, w_bus_err_nxt;
  logic [RET_W-1:0]  r_retired;
  logic              w_ovf, w_hit;

  always_comb begin
    w_cls = C_ILL;
    case (op)
      6'h00: case (irfunc)
        6'h20, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: w_cls = C_ALU;
        6'h08, 6'h09: w_cls = C_JMP;
        default: w_cls = C_ILL;
      endcase
      6'h01: w_cls = (regimm == 5'd0 || regimm == 5'd1) ? C_BR : C_ILL;
      6'h02, 6'h03: w_cls = C_JMP;
      6'h04, 6'h05, 6'h06, 6'h07: w_cls = C_BR;
      6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: w_cls = C_ALU;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w_cls = C_LOAD;
      6'h28, 6'h29, 6'h2b: w_cls = C_STORE;
      default: w_cls = C_ILL;
    endcase
  end

  assign w_ovf = (r_cls == C_ALU) && error && (op == 6'h00) && (irfunc == 6'h20 || irfunc == 6'h22);
  assign w_hit = (r_wait == WAIT_W'(WAIT_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p       <= S_F;
      r_cls     <= C_NONE;
      r_wait    <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else if (stall) begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_p       <= w_p_nxt;
      r_cls     <= w_cls_nxt;
      r_wait    <= w_wait_nxt;
      r_done    <= w_done_nxt;
      r_abort   <= w_abort_nxt;
      r_bus_err <= w_bus_err_nxt;
      if (w_done_nxt) r_retired <= r_retired + RET_W'(1);
    end
  end

  // Any non-one-hot phase falls through to the default and recovers to FETCH.
  always_comb begin
    w_p_nxt       = S_F;
    w_cls_nxt     = r_cls;
    w_wait_nxt    = '0;
    w_done_nxt    = 1'b0;
    w_abort_nxt   = 1'b0;
    w_bus_err_nxt = r_bus_err;
    case (r_p)
      S_F: begin
        if (mem_ready) w_p_nxt = S_D;
        else if (w_hit) w_bus_err_nxt = 1'b1;
        else w_wait_nxt = r_wait + WAIT_W'(1);
      end
      S_D: begin
        w_cls_nxt   = w_cls;
        w_abort_nxt = (w_cls == C_ILL);
        w_p_nxt     = (w_cls == C_ILL) ? S_F : S_E;
      end
      S_E: begin
        w_abort_nxt = w_ovf;
        w_done_nxt  = !w_ovf && (r_cls == C_BR);
        w_p_nxt     = w_ovf ? S_F :
                      (r_cls == C_ALU || r_cls == C_JMP) ? S_W :
                      (r_cls == C_LOAD || r_cls == C_STORE) ? S_M : S_F;
      end
      S_M: begin
        if (mem_ready) begin
          w_p_nxt    = (r_cls == C_LOAD) ? S_W : S_F;
          w_done_nxt = (r_cls != C_LOAD);
        end else if (w_hit) begin
          w_bus_err_nxt = 1'b1;
        end else begin
          w_p_nxt    = S_M;
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      S_W: w_done_nxt = 1'b1;
      default: w_p_nxt = S_F;
    endcase
  end

  always_comb begin
    p          = r_p;
    instr_done = r_done;
    exc_abort  = r_abort;
    bus_err    = r_bus_err;
    retired    = r_retired;
  end
endmodule

// File: tb/tb_mc_phase_seq.sv
// tb_mc_phase_seq: directed scenario tests for the phase sequencer with
// hand-computed phase sequences and pulse/counter expectations.
module tb_mc_phase_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = '0;
  logic [5:0]  irfunc = '0;
  logic [4:0]  regimm = '0;
  logic        error = 1'b0;
  logic        mem_ready = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  p;
  logic        instr_done, exc_abort, bus_err;
  logic [15:0] retired;
  int          errors = 0;
  int          checks = 0;

  mc_phase_seq dut (
    .clk(clk), .reset(reset), .op(op), .irfunc(irfunc), .regimm(regimm),
    .error(error), .mem_ready(mem_ready), .stall(stall), .p(p),
    .instr_done(instr_done), .exc_abort(exc_abort), .bus_err(bus_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; op = '0; irfunc = '0; regimm = '0; error = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (p !== 5'h01) begin errors++; $display("FAIL reset_p got=%h exp=01", p); end
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", instr_done); end
    checks++; if (exc_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", exc_abort); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_buserr got=%b exp=0", bus_err); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
  endtask

  task automatic test_addiu();
    logic [4:0] ep [4] = '{5'h02, 5'h04, 5'h10, 5'h01};
    logic       ed [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    op = 6'h09; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (p !== ep[i]) begin errors++; $display("FAIL addiu_p[%0d] got=%h exp=%h", i, p, ep[i]); end
      checks++; if (instr_done !== ed[i]) begin errors++; $display("FAIL addiu_done[%0d] got=%b exp=%b", i, instr_done, ed[i]); end
    end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL addiu_retired got=%0d exp=1", retired); end
    tick();
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL addiu_done_pulse got=%b exp=0", instr_done); end
  endtask

  task automatic test_lw_wait();
    logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] ep [8] = '{5'h02, 5'h04, 5'h08, 5'h08, 5'h08, 5'h08, 5'h10, 5'h01};
    do_reset();
    op = 6'h23;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rd[i];
      tick();
      checks++; if (p !== ep[i]) begin errors++; $display("FAIL lw_p[%0d] got=%h exp=%h", i, p, ep[i]); end
    end
    checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL lw_done got=%b exp=1", instr_done); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL lw_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] eo [7] = '{6'h04, 6'h04, 6'h04, 6'h2b, 6'h2b, 6'h2b, 6'h2b};
    logic [4:0] ep [7] = '{5'h02, 5'h04, 5'h01, 5'h02, 5'h04, 5'h08, 5'h01};
    logic       ed [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      op = eo[i];
      tick();
      checks++; if (p !== ep[i]) begin errors++; $display("FAIL b2b_p[%0d] got=%h exp=%h", i, p, ep[i]); end
      checks++; if (instr_done !== ed[i]) begin errors++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, instr_done, ed[i]); end
    end
    checks++; if (retired !== 16'd2) begin errors++; $display("FAIL b2b_retired got=%0d exp=2", retired); end
  endtask

  task automatic test_exceptions();
    do_reset();
    op = 6'h00; irfunc = 6'h20; error = 1'b1; mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (p !== 5'h01) begin errors++; $display("FAIL ovf_p got=%h exp=01", p); end
    checks++; if (exc_abort !== 1'b1) begin errors++; $display("FAIL ovf_abort got=%b exp=1", exc_abort); end
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL ovf_done got=%b exp=0", instr_done); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL ovf_retired got=%0d exp=0", retired); end
    tick();
    checks++; if (exc_abort !== 1'b0) begin errors++; $display("FAIL ovf_pulse got=%b exp=0", exc_abort); end
    do_reset();
    op = 6'h00; irfunc = 6'h23; error = 1'b1; mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (p !== 5'h10) begin errors++; $display("FAIL subu_p got=%h exp=10", p); end
    tick();
    checks++; if (instr_done !== 1'b1 || exc_abort !== 1'b0) begin errors++; $display("FAIL subu_done got=%b/%b exp=1/0", instr_done, exc_abort); end
    do_reset();
    op = 6'h3f; mem_ready = 1'b1;
    tick(); tick();
    checks++; if (p !== 5'h01) begin errors++; $display("FAIL ill_p got=%h exp=01", p); end
    checks++; if (exc_abort !== 1'b1) begin errors++; $display("FAIL ill_abort got=%b exp=1", exc_abort); end
    tick();
    checks++; if (exc_abort !== 1'b0 || retired !== 16'd0) begin errors++; $display("FAIL ill_after got=%b/%0d exp=0/0", exc_abort, retired); end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (p !== 5'h01 || bus_err !== 1'b0) begin errors++; $display("FAIL to_pre got=%h/%b exp=01/0", p, bus_err); end
    tick();
    checks++; if (p !== 5'h01 || bus_err !== 1'b1) begin errors++; $display("FAIL to_hit got=%h/%b exp=01/1", p, bus_err); end
    mem_ready = 1'b1;
    tick();
    checks++; if (p !== 5'h02 || bus_err !== 1'b1) begin errors++; $display("FAIL to_sticky got=%h/%b exp=02/1", p, bus_err); end
    do_reset();
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    tick();
    checks++; if (p !== 5'h02 || bus_err !== 1'b0) begin errors++; $display("FAIL to_ready_wins got=%h/%b exp=02/0", p, bus_err); end
    do_reset();
    op = 6'h23; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (p !== 5'h01 || bus_err !== 1'b1) begin errors++; $display("FAIL to_mem got=%h/%b exp=01/1", p, bus_err); end
    checks++; if (instr_done !== 1'b0 || exc_abort !== 1'b0 || retired !== 16'd0) begin errors++; $display("FAIL to_mem_flags got=%b/%b/%0d exp=0/0/0", instr_done, exc_abort, retired); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    op = 6'h23; mem_ready = 1'b1;
    tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (p !== 5'h08 || instr_done !== 1'b0 || retired !== 16'd0) begin errors++; $display("FAIL stall[%0d] got=%h/%b/%0d exp=08/0/0", i, p, instr_done, retired); end
    end
    stall = 1'b0;
    tick();
    checks++; if (p !== 5'h10) begin errors++; $display("FAIL stall_resume got=%h exp=10", p); end
    tick();
    checks++; if (p !== 5'h01 || retired !== 16'd1) begin errors++; $display("FAIL stall_done got=%h/%0d exp=01/1", p, retired); end
    op = 6'h09;
    tick(); tick(); tick();
    checks++; if (p !== 5'h10) begin errors++; $display("FAIL wb_reach got=%h exp=10", p); end
    #2 reset = 1'b1;
    #1;
    checks++; if (p !== 5'h01 || retired !== 16'd0) begin errors++; $display("FAIL async_reset got=%h/%0d exp=01/0", p, retired); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_lw_wait();
    test_back_to_back();
    test_exceptions();
    test_timeout();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
